// File: rtl/clock_pkg.sv
// Shared constants and helpers for the multiplexed BCD display clock:
// 7-segment font, glyphs, BCD field offsets, 12 h conversion and set-time validation.
package clock_pkg;

  localparam int unsigned SS_LSB = 0;
  localparam int unsigned MM_LSB = 8;
  localparam int unsigned HH_LSB = 16;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_DP    = 8'h80;

  // Active-high {dp,g,f,e,d,c,b,a}; non-decimal codes render blank.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // 24 h BCD hour -> 12 h BCD hour (00 -> 12, 13..23 -> 01..11).
  function automatic logic [7:0] to_12h(input logic [7:0] hh);
    logic [4:0] h;
    h = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
    if (h == 5'd0) begin
      h = 5'd12;
    end else if (h > 5'd12) begin
      h = h - 5'd12;
    end
    if (h >= 5'd10) begin
      return {4'd1, 4'(h - 5'd10)};
    end
    return {4'd0, h[3:0]};
  endfunction

  function automatic logic bcd_time_valid(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok && (t[SS_LSB +: 8] <= 8'h59) && (t[MM_LSB +: 8] <= 8'h59) &&
           (t[HH_LSB +: 8] <= 8'h23);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at {MAX_TENS,MAX_UNITS}; load has priority over inc.
module bcd_mod_counter #(
  parameter logic [3:0] MAX_TENS  = 4'd5,
  parameter logic [3:0] MAX_UNITS = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] val,
  output logic [7:0] val_nxt,
  output logic       carry_out
);

  logic [7:0] val_q, val_d;
  logic       at_max;

  assign at_max    = (val_q == {MAX_TENS, MAX_UNITS});
  assign carry_out = inc && !load && at_max;

  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = load_val;
    end else if (inc) begin
      if (at_max) begin
        val_d = 8'h00;
      end else if (val_q[3:0] == 4'd9) begin
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      end else begin
        val_d = {val_q[7:4], val_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q <= 8'h00;
    end else begin
      val_q <= val_d;
    end
  end

  assign val     = val_q;
  assign val_nxt = val_d;

endmodule

// File: rtl/clock_mux_v2.sv
// HH:MM:SS BCD clock with time set, 12/24 h display, hh:mm alarm and an
// 8-position multiplexed 7-segment driver with configurable polarity.
module clock_mux_v2 import clock_pkg::*; #(
  parameter int unsigned CLK_HZ      = 32_000_000,
  parameter int unsigned SCAN_DIV    = 16384,
  parameter bit          DIG_ACT_LOW = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          SEP_BLINK   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        mode_12h,
  input  logic        set_stb,
  input  logic [23:0] set_time,
  input  logic        alarm_en,
  input  logic [15:0] alarm_hm,
  input  logic        alarm_ack,
  output logic [23:0] time_bcd,
  output logic        sec_tick,
  output logic        set_err,
  output logic        alarm,
  output logic [7:0]  dig,
  output logic [7:0]  seg
);

  localparam int unsigned   PW         = $clog2(CLK_HZ);
  localparam int unsigned   SW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
  localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);
  localparam logic [7:0]    DIG_OFF    = DIG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]    SEG_OFF    = SEG_ACT_LOW ? 8'hFF : 8'h00;

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [2:0]    idx_q, idx_d;
  logic          set_err_q, alarm_q, alarm_d;
  logic [7:0]    dig_q, dig_d, seg_q, seg_d, glyph;
  logic          load, tick_raw, tick, ss_carry, mm_carry, hh_carry_unused, alarm_hit;
  logic [7:0]    ss, mm, hh, ss_nxt, mm_nxt, hh_nxt, hh_disp;
  logic          sep_on, pm;

  assign load     = set_stb && bcd_time_valid(set_time);
  assign tick_raw = run && (presc_q == PRESC_MAX);
  // A valid load restarts the second, so a coincident tick is dropped.
  assign tick     = tick_raw && !load;
  assign sec_tick = tick;

  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = tick_raw ? '0 : presc_q + PW'(1);
    end
  end

  bcd_mod_counter #(.MAX_TENS(4'd5), .MAX_UNITS(4'd9)) u_ss (
    .clk(clk), .rst(rst), .inc(tick), .load(load), .load_val(set_time[SS_LSB +: 8]),
    .val(ss), .val_nxt(ss_nxt), .carry_out(ss_carry)
  );

  bcd_mod_counter #(.MAX_TENS(4'd5), .MAX_UNITS(4'd9)) u_mm (
    .clk(clk), .rst(rst), .inc(ss_carry), .load(load), .load_val(set_time[MM_LSB +: 8]),
    .val(mm), .val_nxt(mm_nxt), .carry_out(mm_carry)
  );

  bcd_mod_counter #(.MAX_TENS(4'd2), .MAX_UNITS(4'd3)) u_hh (
    .clk(clk), .rst(rst), .inc(mm_carry), .load(load), .load_val(set_time[HH_LSB +: 8]),
    .val(hh), .val_nxt(hh_nxt), .carry_out(hh_carry_unused)
  );

  // ss_carry implies the new seconds are 00 and that this is a tick, never a load.
  assign alarm_hit = ss_carry && ({hh_nxt, mm_nxt} == alarm_hm);

  always_comb begin
    alarm_d = alarm_q;
    if (!alarm_en || alarm_ack) begin
      alarm_d = 1'b0;
    end else if (alarm_hit) begin
      alarm_d = 1'b1;
    end else if (ss_carry) begin
      alarm_d = 1'b0;
    end
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
      idx_d  = idx_q + 3'd1;
    end
  end

  // Glyphs are built from next-state values so dig/seg line up with the state registers.
  assign hh_disp = mode_12h ? to_12h(hh_nxt) : hh_nxt;
  assign pm      = mode_12h && (hh_nxt >= 8'h12);
  assign sep_on  = !SEP_BLINK || (presc_d < PRESC_HALF);

  always_comb begin
    glyph = SEG_BLANK;
    unique case (idx_d)
      3'd0:       glyph = seg7(ss_nxt[3:0]);
      3'd1:       glyph = seg7(ss_nxt[7:4]);
      3'd2, 3'd5: glyph = sep_on ? SEG_DASH : SEG_BLANK;
      3'd3:       glyph = seg7(mm_nxt[3:0]);
      3'd4:       glyph = seg7(mm_nxt[7:4]);
      3'd6:       glyph = seg7(hh_disp[3:0]) | (pm ? SEG_DP : SEG_BLANK);
      3'd7:       glyph = (mode_12h && hh_disp[7:4] == 4'd0) ? SEG_BLANK : seg7(hh_disp[7:4]);
      default:    glyph = SEG_BLANK;
    endcase
    seg_d = SEG_ACT_LOW ? ~glyph : glyph;
    dig_d = DIG_ACT_LOW ? ~(8'b1 << idx_d) : (8'b1 << idx_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q   <= '0;
      scan_q    <= '0;
      idx_q     <= 3'd0;
      set_err_q <= 1'b0;
      alarm_q   <= 1'b0;
      dig_q     <= DIG_OFF;
      seg_q     <= SEG_OFF;
    end else begin
      presc_q   <= presc_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      set_err_q <= set_stb && !load;
      alarm_q   <= alarm_d;
      dig_q     <= dig_d;
      seg_q     <= seg_d;
    end
  end

  assign time_bcd = {hh, mm, ss};
  assign set_err  = set_err_q;
  assign alarm    = alarm_q;
  assign dig      = dig_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_clock_mux_v2.sv
// Directed bench for clock_mux_v2 with a small expectation queue (CLK_HZ=10, SCAN_DIV=4).
module tb_clock_mux_v2;

  logic        clk, rst, run, mode_12h, set_stb, alarm_en, alarm_ack;
  logic [23:0] set_time, time_bcd;
  logic [15:0] alarm_hm;
  logic        sec_tick, set_err, alarm;
  logic [7:0]  dig, seg;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tick_at[$];

  clock_mux_v2 #(
    .CLK_HZ(10), .SCAN_DIV(4), .DIG_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b0), .SEP_BLINK(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h), .set_stb(set_stb),
    .set_time(set_time), .alarm_en(alarm_en), .alarm_hm(alarm_hm), .alarm_ack(alarm_ack),
    .time_bcd(time_bcd), .sec_tick(sec_tick), .set_err(set_err), .alarm(alarm),
    .dig(dig), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty observed=%0h expected=<none>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic set_load(input logic [23:0] t);
    set_stb  = 1'b1;
    set_time = t;
    step(1);
    set_stb  = 1'b0;
  endtask

  task automatic wait_dig(input logic [7:0] v);
    push($sformatf("wait_dig_%02h", v), {24'h0, v});
    for (int i = 0; i < 64; i++) begin
      if (dig === v) break;
      step(1);
    end
    pop_check({24'h0, dig});
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; mode_12h = 1'b0; set_stb = 1'b0; set_time = '0;
    alarm_en = 1'b0; alarm_hm = '0; alarm_ack = 1'b0;
    step(2);

    // Reset state
    push("rst_time", 32'h0);  pop_check(time_bcd);
    push("rst_tick", 32'h0);  pop_check(sec_tick);
    push("rst_err", 32'h0);   pop_check(set_err);
    push("rst_alarm", 32'h0); pop_check(alarm);
    push("rst_dig", 32'hFF);  pop_check(dig);
    push("rst_seg", 32'h00);  pop_check(seg);

    // 1: free-run, ticks at presc==9, time follows one cycle later
    rst = 1'b1; run = 1'b1;
    push("tick_count", 32'd3); push("tick_first", 32'd9);
    push("tick_gap0", 32'd10); push("tick_gap1", 32'd10); push("time_3s", 32'h000003);
    for (int e = 1; e <= 30; e++) begin
      step(1);
      if (sec_tick === 1'b1) tick_at.push_back(e);
    end
    pop_check(tick_at.size());
    pop_check(tick_at.size() > 0 ? tick_at[0] : -1);
    pop_check(tick_at.size() > 1 ? tick_at[1] - tick_at[0] : -1);
    pop_check(tick_at.size() > 2 ? tick_at[2] - tick_at[1] : -1);
    pop_check(time_bcd);

    // 2: load and hour rollover
    set_load(24'h235958);
    push("load_val", 32'h235958); pop_check(time_bcd);
    push("load_noerr", 32'h0);    pop_check(set_err);
    push("t_235959", 32'h235959); step(10); pop_check(time_bcd);
    push("t_rollover", 32'h0);    step(10); pop_check(time_bcd);

    // 3: invalid set, then load coincident with tick
    set_load(24'h126100);
    push("err_pulse", 32'h1);  pop_check(set_err);
    push("err_keep", 32'h0);   pop_check(time_bcd);
    push("err_single", 32'h0); step(1); pop_check(set_err);
    for (int i = 0; i < 20 && sec_tick !== 1'b1; i++) step(1);
    push("tick_seen", 32'h1);  pop_check(sec_tick);
    set_load(24'h101010);
    push("coinc_load", 32'h101010);  pop_check(time_bcd);
    push("presc_clr", 32'h101010);   step(9); pop_check(time_bcd);
    push("after_clr", 32'h101011);   step(1); pop_check(time_bcd);

    // 4: alarm raise, ack, auto-stop, coincident ack, load-no-raise, enable drop
    alarm_hm = 16'h0001; alarm_en = 1'b1;
    set_load(24'h000059);
    push("al_idle", 32'h0);     pop_check(alarm);
    push("al_raise", 32'h1);    step(10); pop_check(alarm);
    alarm_ack = 1'b1;
    push("al_ack", 32'h0);      step(1); pop_check(alarm);
    alarm_ack = 1'b0;
    set_load(24'h000059);
    push("al_raise2", 32'h1);   step(10); pop_check(alarm);
    push("al_t0159", 32'h000159); push("al_hold", 32'h1);
    step(590); pop_check(time_bcd); pop_check(alarm);
    push("al_t0200", 32'h000200); push("al_auto", 32'h0);
    step(10); pop_check(time_bcd); pop_check(alarm);
    set_load(24'h000059);
    step(9); alarm_ack = 1'b1;
    push("al_coinc", 32'h0); push("al_coinc_t", 32'h000100);
    step(1); pop_check(alarm); pop_check(time_bcd);
    alarm_ack = 1'b0;
    set_load(24'h000100);
    push("al_load", 32'h0);     pop_check(alarm);
    set_load(24'h000059);
    push("al_raise3", 32'h1);   step(10); pop_check(alarm);
    alarm_en = 1'b0;
    push("al_en_off", 32'h0);   step(1); pop_check(alarm);

    // 5: 12 h display
    mode_12h = 1'b1;
    set_load(24'h130507);
    wait_dig(8'hBF); push("h0_pm", 32'h86); pop_check(seg);
    wait_dig(8'h7F); push("h1_blank", 32'h00); pop_check(seg);
    push("t24_kept", 32'h13); pop_check(time_bcd[23:16]);
    set_load(24'h000000);
    wait_dig(8'hBF); push("h0_12", 32'h5B); pop_check(seg);
    wait_dig(8'h7F); push("h1_12", 32'h06); pop_check(seg);
    mode_12h = 1'b0;

    // 6: scan walk and separator blink
    wait_dig(8'h7F);
    wait_dig(8'hFE);
    for (int p = 0; p < 8; p++) begin
      push($sformatf("dig_first_%0d", p), {24'h0, ~(8'b1 << p)}); pop_check(dig);
      step(3);
      push($sformatf("dig_last_%0d", p), {24'h0, ~(8'b1 << p)}); pop_check(dig);
      step(1);
    end
    set_load(24'h000000);
    for (int c = 0; c < 40; c++) begin
      if (dig === 8'hFB || dig === 8'hDF) begin
        push($sformatf("sep_c%0d", c), (c % 10) < 5 ? 32'h40 : 32'h00);
        pop_check(seg);
      end
      step(1);
    end

    // Reset mid-scan takes effect without a clock edge
    #2 rst = 1'b0;
    #1;
    push("mid_rst_dig", 32'hFF); pop_check(dig);
    push("mid_rst_seg", 32'h00); pop_check(seg);
    push("mid_rst_time", 32'h0); pop_check(time_bcd);
    rst = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
